// File: rtl/riscv_mmio_uart_tx_if.sv
// Data-memory port bundle shared by the core (master) and MMIO responders (slave).
interface riscv_mmio_uart_tx_if;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] wdata;
  logic [1:0]  mask_sel;
  logic [31:0] dout;

  modport master (
    output addr,
    output write_en,
    output wdata,
    output mask_sel,
    input  dout
  );

  modport slave (
    input  addr,
    input  write_en,
    input  wdata,
    input  mask_sel,
    output dout
  );
endinterface

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory port.
// 16-byte window: TXDATA (push into FIFO), STATUS, DIV, reserved.
// Bytes are serialized LSB first; tx is registered and idles high.
module riscv_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      x_reset,
  riscv_mmio_uart_tx_if.slave       bus,
  output logic                      tx,
  output logic                      irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Registers
  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic [15:0]     r_div_lat;
  logic [7:0]      r_sh;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit;
  logic            r_tx;

  // Decode and FIFO wires
  logic            w_sel;
  logic [1:0]      w_off;
  logic            w_wr;
  logic            w_push;
  logic            w_push_ok;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_ovf_clr;
  logic            w_div_wr;
  logic [15:0]     w_div_wdata;
  logic [7:0]      w_count8;
  logic [31:0]     w_dout;
  logic            w_unused_bits;

  // FSM next-state wires
  state_t          w_state_nxt;
  logic [7:0]      w_sh_nxt;
  logic [15:0]     w_baud_nxt;
  logic [2:0]      w_bit_nxt;
  logic [15:0]     w_divl_nxt;
  logic            w_tx_nxt;
  logic            w_pop;
  logic            w_bit_end;

  assign w_sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = bus.addr[3:2];
  assign w_wr        = bus.write_en & w_sel;
  assign w_push      = w_wr & (w_off == 2'd0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push_ok   = w_push & ~w_full;
  assign w_ovf_clr   = w_wr & (w_off == 2'd1) & bus.wdata[3];
  assign w_div_wr    = w_wr & (w_off == 2'd2);
  assign w_div_wdata = (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
  assign w_busy      = (r_state != S_IDLE);
  assign w_count8    = 8'(r_count);
  assign w_bit_end   = (r_baud == (r_div_lat - 16'd1));

  // Width select and upper store lanes have no effect on this block.
  assign w_unused_bits = ^{bus.mask_sel, bus.wdata[31:16], bus.addr[1:0]};

  // Zero-latency register read mux
  always_comb begin
    w_dout = '0;
    if (w_sel) begin
      case (w_off)
        2'd1:    w_dout = {16'h0000, w_count8, 4'h0, r_ovf, w_empty, w_full, w_busy};
        2'd2:    w_dout = {16'h0000, r_div};
        default: w_dout = '0;
      endcase
    end
  end

  assign bus.dout = w_dout;
  assign tx       = r_tx;
  assign irq      = w_empty & (r_state == S_IDLE);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers, count and sticky overflow; fullness uses pre-edge count
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Divisor register, clamped so a bit is never shorter than two clocks
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      r_div <= 16'(CLKS_PER_BIT);
    end else if (w_div_wr) begin
      r_div <= w_div_wdata;
    end
  end

  // Serializer state and datapath registers
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_div_lat <= 16'(CLKS_PER_BIT);
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_sh      <= w_sh_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_div_lat <= w_divl_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Serializer next state; tx is precomputed from the next state so the
  // registered line changes exactly on the bit boundary
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_divl_nxt  = r_div_lat;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_sh_nxt    = r_mem[r_rptr];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_divl_nxt  = r_div;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          w_sh_nxt   = {1'b0, r_sh[7:1]};
          w_bit_nxt  = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_sh_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx: register map, frame timing,
// FIFO overflow, divisor latching, address decode and async reset.
module tb_riscv_mmio_uart_tx;

  logic clk = 1'b0;
  logic x_reset;
  logic tx;
  logic irq;

  int n_checks = 0;
  int n_errors = 0;

  riscv_mmio_uart_tx_if bus ();

  riscv_mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (16)
  ) dut (
    .clk     (clk),
    .x_reset (x_reset),
    .bus     (bus),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.addr     = 32'h0;
    bus.write_en = 1'b0;
    bus.wdata    = 32'h0;
    bus.mask_sel = 2'd0;
  endtask

  // Called at a negedge; the store lands on the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    bus.addr     = a;
    bus.wdata    = d;
    bus.mask_sel = m;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.dout, exp);
  endtask

  // Starting 1ns after the posedge that begins cycle k0 of a frame, check
  // every remaining cycle of the 10-bit frame and the busy flag.
  task automatic check_from(input logic [7:0] b, input int d, input int k0);
    logic e;
    int   idx;
    bus.addr = 32'h0000_1004;
    for (int k = k0; k < 10 * d; k++) begin
      idx = k / d;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = b[idx-1];
      #0;
      check("tx_bit", {31'b0, tx}, {31'b0, e});
      check("busy", {31'b0, bus.dout[0]}, 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for the start bit, check its latency in clocks, then the frame.
  task automatic frame(input logic [7:0] b, input int d, input int expw);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tx !== 1'b0 && n < 200);
    check("start_latency", n, expw);
    if (tx === 1'b0) check_from(b, d, 0);
  endtask

  logic [7:0] t3 [10];

  initial begin
    t3[0] = 8'h01; t3[1] = 8'h80; t3[2] = 8'h3C; t3[3] = 8'hC3; t3[4] = 8'hFF;
    t3[5] = 8'h00; t3[6] = 8'h5A; t3[7] = 8'hA5; t3[8] = 8'h96; t3[9] = 8'h69;

    // Reset state
    bus_idle();
    x_reset = 1'b1;
    repeat (3) @(negedge clk);
    x_reset = 1'b0;
    read_check("rst_status", 32'h0000_1004, 32'h0000_0004);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd1);
    read_check("rst_div", 32'h0000_1008, 32'd16);

    // Single byte 0x55 at the reset divisor
    @(negedge clk);
    bus_write(32'h0000_1000, 32'h0000_0055, 2'd2);
    frame(8'h55, 16, 1);
    check("t1_irq_after", {31'b0, irq}, 32'd1);
    read_check("t1_status_after", 32'h0000_1004, 32'h0000_0004);

    // Ten back-to-back stores at DIV=4: first pops at once, tenth overflows
    @(negedge clk);
    bus_write(32'h0000_1008, 32'd4, 2'd0);
    read_check("t3_div", 32'h0000_1008, 32'd4);
    @(negedge clk);
    bus_write(32'h0000_1000, {24'h0, t3[0]}, 2'd2);
    check("t3_pre_pop_tx", {31'b0, tx}, 32'd1);
    bus_write(32'h0000_1000, {24'h0, t3[1]}, 2'd2);
    check("t3_first_pop_tx", {31'b0, tx}, 32'd0);
    for (int i = 2; i < 10; i++) bus_write(32'h0000_1000, {24'h0, t3[i]}, 2'd2);
    read_check("t3_ovf_status", 32'h0000_1004, 32'h0000_080B);
    @(posedge clk);
    #1;
    check_from(t3[0], 4, 9);
    for (int i = 1; i < 9; i++) frame(t3[i], 4, 1);
    check("t3_irq_after", {31'b0, irq}, 32'd1);
    read_check("t3_status_sticky", 32'h0000_1004, 32'h0000_000C);
    @(negedge clk);
    bus_write(32'h0000_1004, 32'h0000_0008, 2'd0);
    read_check("t3_ovf_cleared", 32'h0000_1004, 32'h0000_0004);

    // Divisor clamp and mid-frame divisor change
    @(negedge clk);
    bus_write(32'h0000_1008, 32'd1, 2'd0);
    read_check("t4_div_clamp", 32'h0000_1008, 32'd2);
    @(negedge clk);
    bus_write(32'h0000_1000, 32'h0000_00C5, 2'd2);
    bus_write(32'h0000_1000, 32'h0000_003A, 2'd2);
    bus_write(32'h0000_1008, 32'd6, 2'd0);
    @(posedge clk);
    #1;
    check_from(8'hC5, 2, 2);
    frame(8'h3A, 6, 1);
    read_check("t4_div6", 32'h0000_1008, 32'd6);

    // Decode: outside window and reserved offset do not push
    @(negedge clk);
    bus_write(32'h0000_2000, 32'h0000_0077, 2'd2);
    bus_write(32'h0000_100C, 32'h0000_0077, 2'd2);
    read_check("t5_status_nopush", 32'h0000_1004, 32'h0000_0004);
    read_check("t5_rd_outside", 32'h0000_2000, 32'h0);
    read_check("t5_rd_rsvd", 32'h0000_100C, 32'h0);
    read_check("t5_rd_txdata", 32'h0000_1000, 32'h0);
    check("t5_tx_idle", {31'b0, tx}, 32'd1);
    @(negedge clk);
    bus_write(32'h0000_1000, 32'h0000_AB12, 2'd1);
    frame(8'h12, 6, 1);

    // Asynchronous reset during DATA bit 3 with three bytes queued
    @(negedge clk);
    bus_write(32'h0000_1000, 32'h0000_00F7, 2'd2);
    bus_write(32'h0000_1000, 32'h0000_0011, 2'd2);
    bus_write(32'h0000_1000, 32'h0000_0022, 2'd2);
    bus_write(32'h0000_1000, 32'h0000_0033, 2'd2);
    repeat (24) @(posedge clk);
    #1;
    check("t6_pre_rst_tx", {31'b0, tx}, 32'd0);
    read_check("t6_pre_rst_status", 32'h0000_1004, 32'h0000_0301);
    #1;
    x_reset = 1'b1;
    #1;
    check("t6_rst_tx", {31'b0, tx}, 32'd1);
    check("t6_rst_irq", {31'b0, irq}, 32'd1);
    read_check("t6_rst_status", 32'h0000_1004, 32'h0000_0004);
    repeat (3) @(negedge clk);
    x_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t6_quiet_tx", {31'b0, tx}, 32'd1);
    end
    read_check("t6_status_after", 32'h0000_1004, 32'h0000_0004);
    read_check("t6_div_after", 32'h0000_1008, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
